// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, class-flag positions and
// the default latency of the float multiplier this queue wraps.
package fp_pkg;

   localparam int FP_SIGN_BIT   = 31;
   localparam int FP_EXP_MSB    = 30;
   localparam int FP_EXP_LSB    = 23;
   localparam int FP_EXP_W      = FP_EXP_MSB - FP_EXP_LSB + 1;
   localparam int FP_FRAC_W     = 23;
   localparam int FP_W          = FP_SIGN_BIT + 1;

   localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

   localparam int FLAG_ZERO     = 0;
   localparam int FLAG_INF      = 1;
   localparam int FLAG_NAN      = 2;
   localparam int FLAG_W        = 3;

   localparam int FPMUL_LATENCY = 5;

   // Zero covers denormals too: only the exponent field is inspected.
   function automatic logic [FLAG_W-1:0] fp_classify(input logic [FP_W-1:0] z);
      logic [FP_EXP_W-1:0]  w_exp;
      logic [FP_FRAC_W-1:0] w_frac;
      w_exp  = z[FP_EXP_LSB +: FP_EXP_W];
      w_frac = z[FP_FRAC_W-1:0];
      fp_classify            = '0;
      fp_classify[FLAG_ZERO] = (w_exp == '0);
      fp_classify[FLAG_INF]  = (w_exp == EXP_MAX) && (w_frac == '0);
      fp_classify[FLAG_NAN]  = (w_exp == EXP_MAX) && (w_frac != '0);
   endfunction

endpackage

// File: rtl/fp_mul_result_queue_if.sv
// Operand, multiplier and result signals of the result queue, bundled with
// a slave view for the block and a master view for whoever drives it.
interface fp_mul_result_queue_if
   import fp_pkg::*;
#(
   parameter int TW = 4
);
   logic              iValid;
   logic              oReady;
   logic [FP_W-1:0]   iA;
   logic [FP_W-1:0]   iB;
   logic [TW-1:0]     iTag;
   logic [FP_W-1:0]   oMulA;
   logic [FP_W-1:0]   oMulB;
   logic [FP_W-1:0]   iMulZ;
   logic              oValid;
   logic              iReady;
   logic [FP_W-1:0]   oZ;
   logic [TW-1:0]     oTag;
   logic [FLAG_W-1:0] oFlags;

   modport slave (
      input  iValid, iA, iB, iTag, iMulZ, iReady,
      output oReady, oMulA, oMulB, oValid, oZ, oTag, oFlags
   );

   modport master (
      output iValid, iA, iB, iTag, iMulZ, iReady,
      input  oReady, oMulA, oMulB, oValid, oZ, oTag, oFlags
   );
endinterface

// File: rtl/fp_result_fifo.sv
// Synchronous FIFO holding captured products; the head is shown directly
// (zero when empty) and the occupancy count is exported for credit logic.
module fp_result_fifo #(
   parameter int W     = 39,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_wr,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   output logic                     o_valid,
   output logic [W-1:0]             o_head,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;

   assign o_valid = (r_count != '0);
   assign w_pop   = i_pop & o_valid;
   assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (i_wr) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally; the count alone tells full from empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/fp_mul_result_queue.sv
// Issue/collect wrapper for a fixed-latency float multiplier: tags ride a
// delay line alongside the multiplier and land, classified, in a result FIFO.
module fp_mul_result_queue
   import fp_pkg::*;
#(
   parameter int LATENCY = FPMUL_LATENCY,
   parameter int DEPTH   = 8,
   parameter int TW      = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   fp_mul_result_queue_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = FP_W + TW + FLAG_W;

   logic          w_accept;
   logic          w_capture;
   logic          r_dl_valid [LATENCY];
   logic [TW-1:0] r_dl_tag   [LATENCY];
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_valid;
   logic [FW-1:0] w_fifo_wdata;
   logic [FW-1:0] w_fifo_head;

   assign bus.oMulA = bus.iA;
   assign bus.oMulB = bus.iB;

   // Credits count every result not yet popped, so a capture always has room.
   assign bus.oReady = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
   assign w_accept   = bus.iValid & bus.oReady;
   assign w_capture  = r_dl_valid[LATENCY-1];

   for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dl
      if (gi == 0) begin : g_first
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_dl_valid[gi] <= 1'b0;
               r_dl_tag[gi]   <= '0;
            end else begin
               r_dl_valid[gi] <= w_accept;
               r_dl_tag[gi]   <= bus.iTag;
            end
         end
      end else begin : g_rest
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               r_dl_valid[gi] <= 1'b0;
               r_dl_tag[gi]   <= '0;
            end else begin
               r_dl_valid[gi] <= r_dl_valid[gi-1];
               r_dl_tag[gi]   <= r_dl_tag[gi-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_inflight <= '0;
      end else begin
         case ({w_accept, w_capture})
            2'b10:   r_inflight <= r_inflight + CW'(1);
            2'b01:   r_inflight <= r_inflight - CW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign w_fifo_wdata = {bus.iMulZ, r_dl_tag[LATENCY-1], fp_classify(bus.iMulZ)};

   fp_result_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_wr    (w_capture),
      .i_wdata (w_fifo_wdata),
      .i_pop   (bus.iReady),
      .o_valid (w_fifo_valid),
      .o_head  (w_fifo_head),
      .o_count (w_fifo_count)
   );

   assign bus.oValid = w_fifo_valid;
   assign bus.oZ     = w_fifo_head[FW-1 -: FP_W];
   assign bus.oTag   = w_fifo_head[FLAG_W +: TW];
   assign bus.oFlags = w_fifo_head[FLAG_W-1:0];
endmodule

// File: tb/tb_fp_mul_result_queue.sv
// Directed and random stimulus for the multiplier result queue, checked
// against a queue-level model of acceptance, visibility time and order.
module tb_fp_mul_result_queue;
   localparam int LAT   = 5;
   localparam int DEPTH = 8;
   localparam int TW    = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   fp_mul_result_queue_if #(.TW(TW)) bus ();

   fp_mul_result_queue #(.LATENCY(LAT), .DEPTH(DEPTH), .TW(TW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Simple float multiply for normal operands (truncating); zero if either is zero/denormal.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [9:0]  e;
      logic [47:0] p;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
      return {s, e[7:0], p[45:23]};
   endfunction

   function automatic logic [2:0] classify(input logic [31:0] z);
      if (z[30:23] == 8'h00) return 3'b001;
      if (z[30:23] == 8'hFF) return (z[22:0] == 23'd0) ? 3'b010 : 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  e;
      logic [22:0] f;
      e = 8'($urandom_range(154, 100));
      f = 23'($urandom);
      return {1'($urandom), e, f};
   endfunction

   // Stand-in multiplier: LAT-deep pipeline, optionally forced to a chosen product.
   logic        ov_en = 1'b0;
   logic [31:0] ov_val = '0;
   logic [31:0] z_pipe [LAT];
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < LAT; i++) z_pipe[i] <= '0;
      end else begin
         z_pipe[0] <= ov_en ? ov_val : fmul(bus.oMulA, bus.oMulB);
         for (int i = 1; i < LAT; i++) z_pipe[i] <= z_pipe[i-1];
      end
   end
   assign bus.iMulZ = z_pipe[LAT-1];

   typedef struct {
      logic [31:0]   z;
      logic [TW-1:0] tag;
      int            vis;
   } item_t;

   item_t q[$];
   int    now = 0;
   int    n_cmp = 0;
   int    n_fail = 0;
   logic  obs_ready, obs_valid;
   int    obs_acc, obs_vcnt, obs_nready, run, max_run;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, now);
      end
   endtask

   // One clock: check outputs, drive inputs, advance model at the edge.
   task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input bit rdy,
                        input bit ovr, input logic [31:0] oval);
      bit ev, er;
      ev = (q.size() > 0) && (q[0].vis <= now);
      er = (q.size() < DEPTH);
      check("oValid", 32'(bus.oValid), 32'(ev));
      check("oReady", 32'(bus.oReady), 32'(er));
      if (ev) begin
         check("oZ", bus.oZ, q[0].z);
         check("oTag", 32'(bus.oTag), 32'(q[0].tag));
         check("oFlags", 32'(bus.oFlags), 32'(classify(q[0].z)));
      end else begin
         check("oZ_empty", bus.oZ, 32'd0);
         check("oTag_empty", 32'(bus.oTag), 32'd0);
      end
      obs_ready = bus.oReady;
      obs_valid = bus.oValid;
      if (v && obs_ready) obs_acc++;
      if (obs_valid) begin obs_vcnt++; run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (!obs_ready) obs_nready++;
      bus.iValid = v; bus.iA = a; bus.iB = b; bus.iTag = tag; bus.iReady = rdy;
      ov_en = ovr; ov_val = oval;
      @(posedge clk);
      if (ev && rdy) void'(q.pop_front());
      if (v && er) q.push_back('{z: (ovr ? oval : fmul(a, b)), tag: tag, vis: now + LAT + 1});
      now++;
      @(negedge clk);
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 32'd0, 32'd0, '0, rdy, 1'b0, 32'd0);
   endtask

   logic [31:0] cls_val [4];
   logic [2:0]  cls_exp [4];
   int k, pending;

   initial begin
      cls_val = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
      cls_exp = '{3'b001, 3'b010, 3'b100, 3'b000};
      bus.iValid = 1'b0; bus.iA = '0; bus.iB = '0; bus.iTag = '0; bus.iReady = 1'b0;

      // Reset state
      @(negedge clk); @(negedge clk);
      check("rst_oValid", 32'(bus.oValid), 32'd0);
      check("rst_oReady", 32'(bus.oReady), 32'd1);
      check("rst_oZ", bus.oZ, 32'd0);
      check("rst_oTag", 32'(bus.oTag), 32'd0);
      check("rst_oFlags", 32'(bus.oFlags), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Product path and exact latency: 1.5 * 2.0
      cycle(1'b1, 32'h3FC00000, 32'h40000000, 4'd3, 1'b0, 1'b0, 32'd0);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1'b0);
         if (obs_valid) break;
         k++;
      end
      check("latency", 32'(k), 32'(LAT));
      check("mul1_oZ", bus.oZ, 32'h40400000);
      check("mul1_oTag", 32'(bus.oTag), 32'd3);
      check("mul1_oFlags", 32'(bus.oFlags), 32'd0);
      idle(1'b1);

      // -2.0 * 3.0
      cycle(1'b1, 32'hC0000000, 32'h40400000, 4'd5, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < LAT + 1; i++) idle(1'b0);
      check("mul2_oZ", bus.oZ, 32'hC0C00000);
      idle(1'b1);

      // Classification with forced products
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 32'd0, 32'd0, TW'(i), 1'b0, 1'b1, cls_val[i]);
      for (int i = 0; i < LAT + 2; i++) idle(1'b0);
      for (int i = 0; i < 4; i++) begin
         check("cls_flags", 32'(bus.oFlags), 32'(cls_exp[i]));
         idle(1'b1);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Back-pressure: 10 offers, 8 accepted
      obs_acc = 0;
      for (int i = 0; i < 10; i++)
         cycle(1'b1, rand_op(), rand_op(), TW'(i), 1'b0, 1'b0, 32'd0);
      check("bp_accepts", 32'(obs_acc), 32'd8);
      for (int i = 0; i < LAT + 2; i++) idle(1'b0);
      check("bp_full_ready", 32'(bus.oReady), 32'd0);
      check("bp_head_tag", 32'(bus.oTag), 32'd0);
      // Full boundary: pop with iValid=1 does not admit in the same cycle
      cycle(1'b1, rand_op(), rand_op(), 4'd8, 1'b1, 1'b0, 32'd0);
      check("full_same_cycle", 32'(obs_ready), 32'd0);
      check("full_next_cycle", 32'(bus.oReady), 32'd1);
      pending = 8;
      for (int i = 0; i < 60; i++) begin
         cycle(pending < 10, rand_op(), rand_op(), TW'(pending), 1'b1, 1'b0, 32'd0);
         if (pending < 10 && obs_ready) pending++;
      end
      check("bp_late_accepts", 32'(pending), 32'd10);

      // Streaming: 20 back-to-back with consumer ready
      obs_vcnt = 0; obs_nready = 0; run = 0; max_run = 0;
      for (int i = 0; i < 20; i++)
         cycle(1'b1, rand_op(), rand_op(), TW'(i), 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < LAT + 5; i++) idle(1'b1);
      check("stream_valid_cycles", 32'(obs_vcnt), 32'd20);
      check("stream_run", 32'(max_run), 32'd20);
      check("stream_ready_drops", 32'(obs_nready), 32'd0);

      // Reset mid-operation: 2 queued, 3 in flight
      for (int i = 0; i < 5; i++)
         cycle(1'b1, rand_op(), rand_op(), TW'(i + 1), 1'b0, 1'b0, 32'd0);
      idle(1'b0); idle(1'b0);
      check("pre_rst_valid", 32'(bus.oValid), 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_oValid", 32'(bus.oValid), 32'd0);
      check("mid_rst_oReady", 32'(bus.oReady), 32'd1);
      check("mid_rst_oZ", bus.oZ, 32'd0);
      check("mid_rst_oTag", 32'(bus.oTag), 32'd0);
      check("mid_rst_oFlags", 32'(bus.oFlags), 32'd0);
      q.delete();
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;
      obs_vcnt = 0;
      for (int i = 0; i < 15; i++) idle(1'b1);
      check("post_rst_nothing", 32'(obs_vcnt), 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(1, 0) == 1, rand_op(), rand_op(), TW'($urandom),
               $urandom_range(9, 0) < 7, 1'b0, 32'd0);
      for (int i = 0; i < 30; i++) idle(1'b1);
      check("drain_empty", 32'(bus.oValid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_mul_result_queue.md
# fp_mul_result_queue

Issue and collect stage wrapped around the fixed-latency, non-stallable float multiplier. It accepts operand pairs on a valid/ready handshake and drives them straight into the multiplier. It tracks each in-flight operation with a tag through a delay line of the multiplier's latency, then captures the product into an output FIFO with IEEE-754 class flags. Credit-based admission guarantees no product is ever dropped when the consumer back-pressures.

## Interface
Parameters:
- LATENCY, 5, cycles from multiplier operand sample to product on `iMulZ`
- DEPTH, 8, output FIFO entries; power of two, ≥2
- TW, 4, tag width

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
- iValid  in  1  operand pair offered
- oReady  out  1  block can accept
- iA  in  32  operand A, IEEE-754 single
- iB  in  32  operand B
- iTag  in  TW  caller tag, returned with result
- oMulA  out  32  to multiplier iA
- oMulB  out  32  to multiplier iB
- iMulZ  in  32  multiplier product
- oValid  out  1  result available
- iReady  in  1  consumer accepts result
- oZ  out  32  product
- oTag  out  TW  tag of oZ
- oFlags  out  3  [0] zero (exp==0), [1] inf (exp==255, frac==0), [2] NaN (exp==255, frac!=0)

## Operation
- `oMulA = iA`, `oMulB = iB` (combinational pass-through). The multiplier samples every cycle; only accepted cycles are tracked.
- Accept condition: `iValid & oReady`.
- `oReady = (fifo_count + inflight) < DEPTH`.
  - Depends on registered state only; no combinational path from `iValid` or `iReady`.
- Delay line: LATENCY stages of {valid, tag}.
  - Stage 0 loads {accept, iTag} every edge.
  - At the last stage, a set valid means `iMulZ` in that cycle is the product for that tag.
- Capture: when the last stage is valid, write {`iMulZ`, tag, flags(`iMulZ`)} into the FIFO at that edge.
  - This write can never overflow, by the credit rule.
- `inflight`: counter, width clog2(DEPTH)+1. +1 on accept, −1 on capture; both in one cycle leaves it unchanged.
- `fifo_count`: +1 on capture, −1 on pop (`oValid & iReady`); both in one cycle leaves it unchanged.
- `oValid = fifo_count != 0`. `oZ`/`oTag`/`oFlags` show the FIFO head; they are 0 when empty.
- Results leave in acceptance order.
- Flags are computed from `iMulZ` at capture, not at the output.
- Sign, exponent and fraction are passed unmodified.

## Timing
- Reset values:
  - `oValid=0`, `oZ=0`, `oTag=0`, `oFlags=0`.
  - `oReady=1`.
  - FIFO pointers, counters and all delay-line valids are 0.
- Latency: accepted in cycle t; product on `iMulZ` in cycle t+LATENCY; `oValid` in cycle t+LATENCY+1 if the FIFO was empty.
- Throughput: one per cycle sustained while `iReady=1`.
- Full: occupancy==DEPTH drops `oReady`.
  - A pop in that cycle does not admit a same-cycle accept.
  - `oReady` rises the cycle after the pop.
- Simultaneous capture and pop on a non-empty FIFO: both happen, and count is unchanged.
- Capture into an empty FIFO with `iReady=1`: the entry is visible the next cycle, with no bypass.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally; the count disambiguates full from empty.
- Reset asserted mid-operation: in-flight and queued results are discarded immediately (async). The multiplier shares `resetn`, so no stale product is captured afterwards.

## Structure
- Shared package `fp_pkg`:
  - FP32 field widths and positions (sign 31, exp 30:23, frac 22:0).
  - `EXP_MAX = 8'hFF`.
  - Flag bit indices FLAG_ZERO=0, FLAG_INF=1, FLAG_NAN=2.
  - Default multiplier latency constant `FPMUL_LATENCY = 5`.
- One sub-module: `fp_result_fifo`. Synchronous FIFO, width 32+TW+3, depth DEPTH, with write, pop, head and count. The top level holds the delay line, the credit counter and classification.

## Test plan
- Product path with the real multiplier, `iReady=1`:
  - 0x3FC00000 × 0x40000000, tag 3 → `oZ=0x40400000`, `oTag=3`, `oFlags=0`, `oValid` exactly LATENCY+1 cycles after accept.
  - 0xC0000000 × 0x40400000 → `oZ=0xC0C00000`.
- Classification with a stub multiplier driving `iMulZ`:
  - 0x00000000 → flags 3'b001.
  - 0x7F800000 → 3'b010.
  - 0x7FC00000 → 3'b100.
  - 0x3F800000 → 3'b000.
- Back-pressure:
  - With `iReady=0`, offer 10 pairs with tags 0..9. Exactly 8 are accepted and `oReady` stays 0 after them.
  - Raise `iReady`: tags 0..7 come out in order, then 8 and 9 are accepted.
  - No capture is lost.
- Streaming: 20 back-to-back accepts with `iReady=1` → 20 consecutive `oValid` cycles, tags in order, `oReady` never drops.
- Full boundary: at occupancy 8, pop in the same cycle `iValid=1` → no accept that cycle, accept the next cycle.
- Reset mid-operation: assert `resetn=0` with 3 in flight and 2 queued → all outputs at reset values immediately; nothing emerges after release.
